// File: rtl/izh_pkg.sv
// Shared fixed-point constants, saturation bounds and FSM state type for the
// Izhikevich synaptic-current slice.
package izh_pkg;

    localparam int unsigned V_WIDTH_DEF  = 20;
    localparam int unsigned FR_WIDTH_DEF = 11;
    localparam int          ONE          = 1 << FR_WIDTH_DEF;
    localparam int          SAT_MAX      = (1 << (V_WIDTH_DEF - 1)) - 1;
    localparam int          SAT_MIN      = -(1 << (V_WIDTH_DEF - 1));

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/izh_sat_add.sv
// Combinational signed saturating adder; clamps to the representable range
// instead of wrapping.
module izh_sat_add
    import izh_pkg::*;
#(
    parameter int unsigned V_WIDTH = V_WIDTH_DEF
) (
    input  logic signed [V_WIDTH-1:0] a,
    input  logic signed [V_WIDTH-1:0] b,
    output logic signed [V_WIDTH-1:0] y
);

    localparam logic signed [V_WIDTH-1:0] HI = V_WIDTH'(sat_max(V_WIDTH));
    localparam logic signed [V_WIDTH-1:0] LO = V_WIDTH'(sat_min(V_WIDTH));

    logic [V_WIDTH:0] sum;

    always_comb begin
        sum = {a[V_WIDTH-1], a} + {b[V_WIDTH-1], b};
        // overflow shows up as disagreement between the two top sum bits
        if (sum[V_WIDTH] != sum[V_WIDTH-1]) begin
            y = sum[V_WIDTH] ? LO : HI;
        end else begin
            y = sum[V_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/izh_syn_current.sv
// Per-neuron synaptic current accumulator: integrates weighted events between
// ticks, then streams every neuron's current out while applying decay.
module izh_syn_current
    import izh_pkg::*;
#(
    parameter int unsigned V_WIDTH   = V_WIDTH_DEF,
    parameter int unsigned FR_WIDTH  = FR_WIDTH_DEF,
    parameter int unsigned N_NEURON  = 20,
    parameter int unsigned IDX_WIDTH = 5,
    parameter int unsigned TAU_SHIFT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [IDX_WIDTH-1:0]        ev_idx,
    input  logic signed [V_WIDTH-1:0]   ev_weight,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_WIDTH-1:0]        out_idx,
    output logic signed [V_WIDTH-1:0]   out_I,
    output logic                        sweep_done,
    output logic                        err_idx,
    output logic                        tick_overrun
);

    if (FR_WIDTH >= V_WIDTH || N_NEURON > (1 << IDX_WIDTH) || TAU_SHIFT == 0) begin : g_param_check
        $error("izh_syn_current: inconsistent parameter set");
    end

    localparam logic [IDX_WIDTH:0]   N_LIM = (IDX_WIDTH + 1)'(N_NEURON);
    localparam logic [IDX_WIDTH-1:0] LAST  = IDX_WIDTH'(N_NEURON - 1);

    state_t                    state, state_nx;
    logic [IDX_WIDTH-1:0]      cnt;
    logic signed [V_WIDTH-1:0] acc [N_NEURON];

    logic                      ev_ok, ev_fire, out_fire;
    logic signed [V_WIDTH-1:0] ev_cur, ev_sum, sw_cur, sw_dec, sw_new;

    always_comb begin
        ev_ok  = ({1'b0, ev_idx} < N_LIM);
        ev_cur = ev_ok ? acc[ev_idx] : '0;
        sw_cur = acc[cnt];
        // negating a shifted value cannot overflow while TAU_SHIFT >= 1
        sw_dec = -(sw_cur >>> TAU_SHIFT);
    end

    izh_sat_add #(.V_WIDTH(V_WIDTH)) u_add_ev (
        .a (ev_cur),
        .b (ev_weight),
        .y (ev_sum)
    );

    izh_sat_add #(.V_WIDTH(V_WIDTH)) u_add_decay (
        .a (sw_cur),
        .b (sw_dec),
        .y (sw_new)
    );

    always_comb begin
        state_nx   = state;
        ev_ready   = 1'b0;
        out_valid  = 1'b0;
        sweep_done = 1'b0;
        case (state)
            IDLE: begin
                ev_ready = rst_n;
                if (tick) begin
                    state_nx = SWEEP;
                end
            end
            SWEEP: begin
                out_valid = 1'b1;
                if (out_ready && cnt == LAST) begin
                    sweep_done = rst_n;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ev_fire  = ev_valid & ev_ready;
    assign out_fire = out_valid & out_ready;
    assign out_idx  = cnt;
    assign out_I    = sw_cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            err_idx      <= 1'b0;
            tick_overrun <= 1'b0;
            acc          <= '{default: '0};
        end else begin
            state   <= state_nx;
            err_idx <= ev_fire & ~ev_ok;
            if (ev_fire && ev_ok) begin
                acc[ev_idx] <= ev_sum;
            end
            if (state == IDLE && tick) begin
                cnt <= '0;
            end
            if (out_fire) begin
                acc[cnt] <= sw_new;
                cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            if (state == SWEEP && tick) begin
                tick_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_izh_syn_current.sv
// Randomised self-checking bench for izh_syn_current against an arithmetic
// model of per-neuron saturating accumulation and floor-divide decay.
module tb_izh_syn_current;

    localparam int N    = 20;
    localparam int VW   = 20;
    localparam int IW   = 5;
    localparam int TAU  = 2;
    localparam int DIV  = 4;
    localparam int VMAX = 524287;
    localparam int VMIN = -524288;

    logic                 clk = 1'b0;
    logic                 rst_n, tick, ev_valid, ev_ready, out_valid, out_ready;
    logic                 sweep_done, err_idx, tick_overrun;
    logic [IW-1:0]        ev_idx, out_idx;
    logic signed [VW-1:0] ev_weight, out_I;

    int errors = 0;
    int checks = 0;
    int m_acc [N];
    bit m_ovr;
    int obs [N];

    always #5 clk = ~clk;

    izh_syn_current #(
        .V_WIDTH   (VW),
        .FR_WIDTH  (11),
        .N_NEURON  (N),
        .IDX_WIDTH (IW),
        .TAU_SHIFT (TAU)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_idx       (ev_idx),
        .ev_weight    (ev_weight),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_I        (out_I),
        .sweep_done   (sweep_done),
        .err_idx      (err_idx),
        .tick_overrun (tick_overrun)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input longint v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return int'(v);
    endfunction

    function automatic int floor_div(input int v);
        if (v >= 0) return v / DIV;
        return -((-v + DIV - 1) / DIV);
    endfunction

    function automatic int rand_weight();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1048575)) - 524288;
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        m_ovr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; ev_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst ev_ready", int'(ev_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst sweep_done", int'(sweep_done), 0);
        check("rst err_idx", int'(err_idx), 0);
        check("rst tick_overrun", int'(tick_overrun), 0);
        rst_n = 1'b1;
        model_clear();
        #1;
        check("post-rst ev_ready", int'(ev_ready), 1);
    endtask

    task automatic send_event(input int idx, input int w);
        ev_valid = 1'b1; ev_idx = IW'(idx); ev_weight = VW'(w);
        #1;
        check("ev_ready idle", int'(ev_ready), 1);
        step();
        ev_valid = 1'b0;
        if (idx < N) m_acc[idx] = sat(longint'(m_acc[idx]) + w);
        check("err_idx", int'(err_idx), int'(idx >= N));
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 stall 5 cycles at idx2
    // ev_mode: 0 none, 1 event with tick, 2 event held through sweep
    task automatic do_sweep(input int rdy_mode, input bit ovr5, input int rst_at,
                            input int ev_mode, input int e_idx, input int e_w);
        int exp_i = 0;
        int cyc = 0;
        int stall = 0;
        bit ovr_done = 1'b0;
        bit aborted = 1'b0;
        tick = 1'b1;
        if (ev_mode == 1) begin
            ev_valid = 1'b1; ev_idx = IW'(e_idx); ev_weight = VW'(e_w);
        end
        step();
        tick = 1'b0; ev_valid = 1'b0;
        if (ev_mode == 1 && e_idx < N) m_acc[e_idx] = sat(longint'(m_acc[e_idx]) + e_w);
        if (ev_mode == 2) begin
            ev_valid = 1'b1; ev_idx = IW'(e_idx); ev_weight = VW'(e_w);
        end
        while (exp_i < N && cyc < 200) begin
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    out_ready = !(exp_i == 2 && stall < 5);
                    if (!out_ready) stall++;
                end
            endcase
            tick = ovr5 && exp_i == 5 && !ovr_done;
            if (tick) begin
                ovr_done = 1'b1;
                m_ovr = 1'b1;
            end
            if (exp_i == rst_at) rst_n = 1'b0;
            #1;
            check("out_valid", int'(out_valid), 1);
            check("out_idx", int'(out_idx), exp_i);
            check("out_I", int'(out_I), m_acc[exp_i]);
            check("ev_ready sweep", int'(ev_ready), 0);
            check("sweep_done", int'(sweep_done), int'(rst_n && out_ready && exp_i == N - 1));
            obs[exp_i] = int'(out_I);
            step();
            tick = 1'b0;
            cyc++;
            if (!rst_n) begin
                rst_n = 1'b1;
                aborted = 1'b1;
                model_clear();
                break;
            end
            if (out_ready) begin
                m_acc[exp_i] = m_acc[exp_i] - floor_div(m_acc[exp_i]);
                exp_i++;
            end
        end
        out_ready = 1'b0;
        check("sweep bound", int'(cyc < 200), 1);
        check("out_valid after sweep", int'(out_valid), 0);
        check("tick_overrun", int'(tick_overrun), int'(m_ovr));
        if (!aborted && rdy_mode == 0) check("sweep cycles", cyc, N);
        if (ev_mode == 2) begin
            #1;
            check("held ev_ready", int'(ev_ready), 1);
            step();
            ev_valid = 1'b0;
            if (e_idx < N) m_acc[e_idx] = sat(longint'(m_acc[e_idx]) + e_w);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; ev_valid = 1'b0; ev_idx = '0; ev_weight = '0; out_ready = 1'b0;
        do_reset();

        // empty sweep: all zeros, done on idx 19
        do_sweep(0, 1'b0, -1, 0, 0, 0);
        check("empty idx0", obs[0], 0);
        check("empty idx19", obs[N-1], 0);

        // accumulate then decay over three ticks
        send_event(3, 10240);
        send_event(3, 6144);
        do_sweep(0, 1'b0, -1, 0, 0, 0);
        check("idx3 tick1", obs[3], 16384);
        do_sweep(1, 1'b0, -1, 0, 0, 0);
        check("idx3 tick2", obs[3], 12288);
        do_sweep(0, 1'b0, -1, 0, 0, 0);
        check("idx3 tick3", obs[3], 9216);

        // saturation at both rails
        send_event(0, VMAX);
        send_event(0, VMAX);
        send_event(1, VMIN);
        send_event(1, VMIN);
        send_event(5, 3);
        send_event(6, -1);
        do_sweep(0, 1'b0, -1, 0, 0, 0);
        check("sat pos", obs[0], VMAX);
        check("sat neg", obs[1], VMIN);
        do_sweep(0, 1'b0, -1, 0, 0, 0);
        check("small pos no decay", obs[5], 3);
        check("neg decays to 0", obs[6], 0);

        // backpressure with an event held across the sweep
        do_sweep(2, 1'b0, -1, 2, 4, 777);
        do_sweep(0, 1'b0, -1, 0, 0, 0);

        // out-of-range event, then tick mid-sweep
        send_event(25, 1000);
        send_event(2, 50);
        do_sweep(0, 1'b1, -1, 0, 0, 0);

        // randomised traffic
        for (int r = 0; r < 8; r++) begin
            int nev = int'($urandom_range(0, 12));
            for (int k = 0; k < nev; k++) send_event(int'($urandom_range(0, 24)), rand_weight());
            do_sweep(int'($urandom_range(0, 1)), 1'b0, -1, int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 24)), rand_weight());
        end

        // reset mid-sweep, then an all-zero sweep
        send_event(7, 4000);
        send_event(12, -4000);
        do_sweep(0, 1'b0, 7, 0, 0, 0);
        do_sweep(0, 1'b0, -1, 0, 0, 0);
        check("post-abort idx7", obs[7], 0);
        check("post-abort idx12", obs[12], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
